// File: rtl/painter_pkg.sv
// rtl/painter_pkg.sv - shared types, colours and LCD command bytes for the cell painter
package painter_pkg;

   // Object codes delivered by the grid scanner; codes 5..7 are reserved
   typedef enum logic [2:0] {
      OBJ_EMPTY  = 3'd0,
      OBJ_HEAD   = 3'd1,
      OBJ_BODY   = 3'd2,
      OBJ_APPLE  = 3'd3,
      OBJ_BORDER = 3'd4
   } obj_code_e;

   // RGB565 colours
   localparam logic [15:0] COL_EMPTY    = 16'h0000;
   localparam logic [15:0] COL_HEAD     = 16'h07E0;
   localparam logic [15:0] COL_BODY     = 16'h03E0;
   localparam logic [15:0] COL_APPLE    = 16'hF800;
   localparam logic [15:0] COL_BORDER   = 16'h7BEF;
   localparam logic [15:0] COL_RESERVED = 16'hF81F;
   localparam logic [15:0] COL_GRID     = 16'h2104;

   // ILI9341 command bytes
   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   // Painter sequence; each state names the section whose next byte is pending
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CASET  = 3'd1,
      ST_PASET  = 3'd2,
      ST_RAMWR  = 3'd3,
      ST_PIXELS = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Fill colour for an object code; unknown codes show up as magenta
   function automatic logic [15:0] obj_colour(input logic [2:0] code);
      logic [15:0] col;
      case (code)
         OBJ_EMPTY:  col = COL_EMPTY;
         OBJ_HEAD:   col = COL_HEAD;
         OBJ_BODY:   col = COL_BODY;
         OBJ_APPLE:  col = COL_APPLE;
         OBJ_BORDER: col = COL_BORDER;
         default:    col = COL_RESERVED;
      endcase
      return col;
   endfunction

   // Address-window parameter byte: 1..4 -> start hi, start lo, end hi, end lo
   function automatic logic [7:0] window_byte(input logic [15:0] s, input logic [15:0] e,
                                              input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd1:    b = s[15:8];
         3'd2:    b = s[7:0];
         3'd3:    b = e[15:8];
         default: b = e[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - two-phase 8080 write strobe for one bus byte
module lcd_byte_writer (
   input  logic       clk,
   input  logic       nrst,
   input  logic       i_start,
   input  logic       i_dc,
   input  logic [7:0] i_byte,
   output logic       o_ready,
   output logic       o_lcd_wr_n,
   output logic       o_lcd_dc,
   output logic [7:0] o_lcd_d
);

   logic       r_wr_n;
   logic       r_dc;
   logic [7:0] r_d;

   // Phase A drives wr_n low with data; phase B raises wr_n and holds data/dc
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_n <= 1'b1;
         r_dc   <= 1'b1;
         r_d    <= 8'h00;
      end else if (i_start && r_wr_n) begin
         r_wr_n <= 1'b0;
         r_dc   <= i_dc;
         r_d    <= i_byte;
      end else begin
         r_wr_n <= 1'b1;
      end
   end

   // Phase B (or idle) is the slot in which the next byte may be launched,
   // so back-to-back bytes have no gap between them
   assign o_ready    = r_wr_n;
   assign o_lcd_wr_n = r_wr_n;
   assign o_lcd_dc   = r_dc;
   assign o_lcd_d    = r_d;

endmodule

// File: rtl/lcd_cell_painter.sv
// rtl/lcd_cell_painter.sv - paints one grid cell on an 8080 LCD per scanner update; LCD_CELL_GRID_OUTLINE_EN adds a grid outline
module lcd_cell_painter
   import painter_pkg::*;
#(
   parameter int CELL_PX = 20,
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 12
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       en_update,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [2:0] obj_code,
   output logic       cmd_done,
   output logic       busy,
   output logic       lcd_cs_n,
   output logic       lcd_dc,
   output logic       lcd_wr_n,
   output logic [7:0] lcd_d
);

   localparam logic [4:0]  PX_LAST  = 5'(CELL_PX - 1);
   localparam logic [15:0] PX_SPAN  = 16'(CELL_PX - 1);
   localparam logic [4:0]  X_LIMIT  = 5'(GRID_W);
   localparam logic [4:0]  Y_LIMIT  = 5'(GRID_H);

   state_e      r_state;
   state_e      w_next_state;
   logic        r_arm;
   logic [3:0]  r_x;
   logic [3:0]  r_y;
   logic [2:0]  r_obj;
   logic [2:0]  r_idx;
   logic [4:0]  r_col;
   logic [4:0]  r_row;
   logic        r_half;
   logic        r_last;
   logic        r_cs_n;

   logic        w_accept;
   logic        w_off_panel;
   logic        w_ready;
   logic        w_start;
   logic        w_dc;
   logic [7:0]  w_byte;
   logic [15:0] w_xs;
   logic [15:0] w_xe;
   logic [15:0] w_ys;
   logic [15:0] w_ye;
   logic [15:0] w_obj_col;
   logic [15:0] w_pix_col;

   assign w_accept    = (r_state == ST_IDLE) && en_update && r_arm;
   assign w_off_panel = ({1'b0, y} >= Y_LIMIT) || ({1'b0, x} >= X_LIMIT);

   // Address window from the captured cell position (16-bit, constant multiply)
   assign w_xs = 16'(r_x) * 16'(CELL_PX);
   assign w_xe = w_xs + PX_SPAN;
   assign w_ys = 16'(r_y) * 16'(CELL_PX);
   assign w_ye = w_ys + PX_SPAN;

   assign w_obj_col = obj_colour(r_obj);

`ifdef LCD_CELL_GRID_OUTLINE_EN
   // Right column and bottom row of the cell carry the grid line colour
   assign w_pix_col = ((r_col == PX_LAST) || (r_row == PX_LAST)) ? COL_GRID : w_obj_col;
`else
   assign w_pix_col = w_obj_col;
`endif

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and the byte offered to the writer; the CASET command is
   // launched on the accepting edge itself so the bus starts without delay
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_dc         = 1'b1;
      w_byte       = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_off_panel) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_start      = 1'b1;
                  w_dc         = 1'b0;
                  w_byte       = CMD_CASET;
                  w_next_state = ST_CASET;
               end
            end
         end
         ST_CASET: begin
            if (w_ready) begin
               w_start = 1'b1;
               if (r_idx == 3'd0) begin
                  w_dc   = 1'b0;
                  w_byte = CMD_CASET;
               end else begin
                  w_byte = window_byte(w_xs, w_xe, r_idx);
               end
               if (r_idx == 3'd4) begin
                  w_next_state = ST_PASET;
               end
            end
         end
         ST_PASET: begin
            if (w_ready) begin
               w_start = 1'b1;
               if (r_idx == 3'd0) begin
                  w_dc   = 1'b0;
                  w_byte = CMD_PASET;
               end else begin
                  w_byte = window_byte(w_ys, w_ye, r_idx);
               end
               if (r_idx == 3'd4) begin
                  w_next_state = ST_RAMWR;
               end
            end
         end
         ST_RAMWR: begin
            if (w_ready) begin
               w_start      = 1'b1;
               w_dc         = 1'b0;
               w_byte       = CMD_RAMWR;
               w_next_state = ST_PIXELS;
            end
         end
         ST_PIXELS: begin
            if (w_ready) begin
               if (r_last) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_start = 1'b1;
                  w_byte  = r_half ? w_pix_col[7:0] : w_pix_col[15:8];
               end
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Request capture, re-arm after en_update drops, and byte/pixel counters
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_arm  <= 1'b1;
         r_x    <= 4'd0;
         r_y    <= 4'd0;
         r_obj  <= 3'd0;
         r_idx  <= 3'd0;
         r_col  <= 5'd0;
         r_row  <= 5'd0;
         r_half <= 1'b0;
         r_last <= 1'b0;
      end else begin
         if (w_accept) begin
            r_arm <= 1'b0;
         end else if (!en_update) begin
            r_arm <= 1'b1;
         end
         if (w_accept) begin
            r_x   <= x;
            r_y   <= y;
            r_obj <= obj_code;
            r_idx <= 3'd1;
         end else if (w_start) begin
            case (r_state)
               ST_CASET, ST_PASET: begin
                  r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
               end
               ST_RAMWR: begin
                  r_col  <= 5'd0;
                  r_row  <= 5'd0;
                  r_half <= 1'b0;
                  r_last <= 1'b0;
               end
               ST_PIXELS: begin
                  r_half <= ~r_half;
                  if (r_half) begin
                     if (r_col == PX_LAST) begin
                        r_col <= 5'd0;
                        r_row <= r_row + 5'd1;
                        if (r_row == PX_LAST) begin
                           r_last <= 1'b1;
                        end
                     end else begin
                        r_col <= r_col + 5'd1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Chip select follows the state being entered, so it falls with the first
   // strobe and rises as DONE begins
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cs_n <= 1'b1;
      end else begin
         r_cs_n <= (w_next_state == ST_IDLE) || (w_next_state == ST_DONE);
      end
   end

   lcd_byte_writer u_writer (
      .clk        (clk),
      .nrst       (nrst),
      .i_start    (w_start),
      .i_dc       (w_dc),
      .i_byte     (w_byte),
      .o_ready    (w_ready),
      .o_lcd_wr_n (lcd_wr_n),
      .o_lcd_dc   (lcd_dc),
      .o_lcd_d    (lcd_d)
   );

   assign cmd_done = (r_state == ST_DONE);
   assign busy     = (r_state != ST_IDLE);
   assign lcd_cs_n = r_cs_n;

endmodule
